icache_fetch_ctrl: RTL and testbench
====================================

// Module: icache_fetch_ctrl
// PURPOSE
// - Instruction-side responder for the decode stage: returns instr for the fetch pc, with i_rdy.
// - i_rdy=0 stalls all pipeline flops; decode captures instr only when i_rdy=1.
// - Direct-mapped instruction cache held in flops; a miss refills a whole line from main memory
//   through a req/rdy handshake.
// - Sits between the PC logic (IF stage) and the IM_ID flop in the decode stage.
// PARAMETERS
// - LINES       8   number of cache lines; power of 2; index width IDX_W = log2(LINES)
// - LINE_WORDS  4   16-bit words per line (fixed at 4; sets the offset width to 2)
// PORTS
// - clk           in   1   system clock
// - rst_n         in   1   asynchronous active-low reset
// - pc            in   16  word address of the instruction to fetch
// - rd_en         in   1   fetch request; IF holds this high except during halt
// - inv           in   1   one-cycle pulse; invalidates every line
// - instr         out  16  fetched instruction; 16'hB000 (LLB R0,#0) when i_rdy=0
// - i_rdy         out  1   instr valid for this pc; low = stall the pipeline
// - mem_re        out  1   line-read request to main memory
// - mem_addr      out  14  line address = pc[15:2], latched at miss
// - mem_rdy       in   1   mem_rd_data valid this cycle; terminates the request
// - mem_rd_data   in   64  line data; word0 in [15:0] ... word3 in [63:48]
// BEHAVIOUR
// Address fields
// - offset = pc[1:0]; index = pc[2+IDX_W-1:2]; tag = pc[15:2+IDX_W].
// Reset
// - All valid bits = 0, state = IDLE, mem_re = 0, mem_addr = 0, i_rdy = 0, instr = 16'hB000.
// - Tag/data arrays are not reset.
// Hit (combinational, IDLE only)
// - Hit condition: rd_en & valid[index] & (tag_arr[index] == tag).
// - On a hit: i_rdy = 1 and instr = selected word, in the same cycle (zero-latency hit).
// FSM states
// - IDLE: a request that misses latches pc[15:2] into mem_addr, then goes to MISS.
//   - i_rdy = 0 in the miss cycle.
// - MISS: mem_re = 1 and mem_addr is held stable until mem_rdy.
//   - On mem_rdy: write data_arr[idx], set tag_arr[idx] and valid[idx] from the latched
//     address, then go to REFILL. mem_re drops in the following cycle.
//   - mem_rdy in the very first MISS cycle is legal.
// - REFILL: i_rdy = 0, one bubble cycle, then IDLE.
//   - IDLE re-evaluates the current pc, which hits if it is unchanged.
// Miss latency
// - Miss latency = N + 2 cycles, where N = MISS cycles up to and including mem_rdy.
// Boundary conditions
// - pc changes during MISS/REFILL (flow change): the fill completes for the latched address.
//   The new pc is looked up in IDLE and may miss again. No request is ever aborted.
// - rd_en = 0 in IDLE: i_rdy = 0, no miss is started, state stays IDLE.
// - rd_en dropping during MISS: the fill still completes.
// - inv: clears all valid bits at the next edge, in any state.
//   - If inv coincides with mem_rdy, the filled line is left invalid; the FSM still goes to REFILL.
// - Conflict (same index, different tag): the line is overwritten; there is no write-back,
//   because the cache is read-only.
// - Reset mid-miss: mem_re deasserts asynchronously and all lines become invalid.
// - mem_rdy while not in MISS: ignored.
// STRUCTURE
// - Shared include common_params.inc gets:
//   - state encodings IC_IDLE=2'b00, IC_MISS=2'b01, IC_REFILL=2'b10;
//   - NOP_INSTR=16'hB000, shared with the decode-stage reset value.
// - One natural sub-module, icache_array:
//   - holds the valid/tag/data flops, one write port (idx, tag, line, we) and one read port
//     (idx -> valid, tag, line);
//   - has a synchronous write and an asynchronous clear of valid bits on rst_n.
// - FSM, hit compare and word select stay in icache_fetch_ctrl.
// TESTING
// - Cold miss: reset, pc=16'h0000, rd_en=1, mem_rdy 3 cycles after mem_re.
//   - Required: mem_addr=14'h0000; i_rdy=0 for 5 cycles; then i_rdy=1 with instr=mem_rd_data[15:0].
// - Hit streak: after the fill above, pc=1,2,3 on successive cycles.
//   - Required: i_rdy=1 every cycle, instr = words 1..3, mem_re never asserted.
// - Conflict: fill pc=16'h0000, then pc=16'h0020 (same index 0, new tag), then pc=16'h0000.
//   - Required: two further misses, with mem_addr=14'h0008 and then 14'h0000.
// - Flow change during MISS: miss on pc=16'h0010, then change pc to 16'h0004 during MISS.
//   - Required: line 14'h0004 filled first; then a second miss with mem_addr=14'h0001;
//     i_rdy rises only for pc=16'h0004.
// - inv coincident with mem_rdy: keep pc constant.
//   - Required: REFILL, then an immediate re-miss on the same mem_addr.
//   - inv while IDLE on a previously hit pc: the next lookup misses.
// - Reset mid-MISS: assert rst_n=0 while mem_re=1.
//   - Required: mem_re=0 and i_rdy=0 immediately, with no clk edge needed;
//     after release, a previously filled pc misses.

Source files
------------

// File: rtl/icache_fetch_ctrl_pkg.sv
// Shared constants for the instruction-cache fetch controller: geometry,
// FSM state encodings and the decode-stage NOP value.
package icache_fetch_ctrl_pkg;

    // Cache geometry defaults
    localparam int IC_LINES      = 8;
    localparam int IC_LINE_WORDS = 4;
    localparam int IC_WORD_W     = 16;
    localparam int IC_PC_W       = 16;

    // FSM state encodings
    localparam logic [1:0] IC_IDLE   = 2'b00;
    localparam logic [1:0] IC_MISS   = 2'b01;
    localparam logic [1:0] IC_REFILL = 2'b10;

    // LLB R0,#0 -- same value the decode stage resets its IM_ID flop to
    localparam logic [15:0] NOP_INSTR = 16'hB000;

endpackage

// File: rtl/icache_fetch_ctrl_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One synchronous write port used by the refill, one asynchronous read port
// used by the lookup. Valid bits clear asynchronously on reset and
// synchronously on i_clr; tags and data are never reset.
import icache_fetch_ctrl_pkg::*;

module icache_array #(
    parameter int LINES  = 8,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 11,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_line,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_line
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_line [LINES];

    // Valid bits: clear wins over a coincident fill, so a line filled in the
    // same cycle as an invalidate is left invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clr) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written only by a completed refill
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_line[i_wr_idx] <= i_wr_line;
        end
    end

    // Asynchronous read port for the zero-latency lookup
    always_comb begin
        o_rd_valid = r_valid[i_rd_idx];
        o_rd_tag   = r_tag[i_rd_idx];
        o_rd_line  = r_line[i_rd_idx];
    end

endmodule

// File: rtl/icache_fetch_ctrl.sv
// Instruction fetch responder for the decode stage. Hits return the word in
// the same cycle; a miss refills the whole line from main memory through a
// mem_re/mem_rdy handshake, then spends one bubble cycle before re-looking up.
//
// Memory handshake: mem_re is high for every MISS cycle with mem_addr stable;
// the request ends in the cycle mem_rdy is high, and mem_rd_data is taken in
// that same cycle. mem_rdy outside MISS is ignored. Requests are never aborted.
import icache_fetch_ctrl_pkg::*;

module icache_fetch_ctrl #(
    parameter int LINES      = IC_LINES,
    parameter int LINE_WORDS = IC_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        rd_en,
    input  logic        inv,
    output logic [15:0] instr,
    output logic        i_rdy,
    output logic        mem_re,
    output logic [13:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [63:0] mem_rd_data,
    output logic [1:0]  dbg_state
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LA_W   = IC_PC_W - OFF_W;
    localparam int TAG_W  = LA_W - IDX_W;
    localparam int LINE_W = LINE_WORDS * IC_WORD_W;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [LA_W-1:0]   r_mem_addr;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [LINE_W-1:0] w_rd_line;
    logic              w_lookup;
    logic              w_hit;
    logic              w_miss;
    logic              w_fill;

    // Split the fetch pc into offset / index / tag
    always_comb begin
        w_off = pc[OFF_W-1:0];
        w_idx = pc[OFF_W +: IDX_W];
        w_tag = pc[IC_PC_W-1 -: TAG_W];
    end

    icache_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (inv),
        .i_we       (w_fill),
        .i_wr_idx   (r_mem_addr[IDX_W-1:0]),
        .i_wr_tag   (r_mem_addr[LA_W-1 -: TAG_W]),
        .i_wr_line  (mem_rd_data),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line)
    );

    // Lookup only happens in IDLE; MISS and REFILL always stall
    always_comb begin
        w_lookup = (r_state == IC_IDLE) && rd_en;
        w_hit    = w_lookup && w_rd_valid && (w_rd_tag == w_tag);
        w_miss   = w_lookup && !(w_rd_valid && (w_rd_tag == w_tag));
        w_fill   = (r_state == IC_MISS) && mem_rdy;
    end

    // Outputs to decode and memory; instr falls back to the NOP when stalled
    always_comb begin
        i_rdy     = w_hit;
        instr     = NOP_INSTR;
        if (w_hit) begin
            instr = w_rd_line[{w_off, 4'b0000} +: IC_WORD_W];
        end
        mem_re    = (r_state == IC_MISS);
        mem_addr  = r_mem_addr;
        dbg_state = r_state;
    end

    // Next-state logic: IDLE -> MISS on a miss, MISS -> REFILL on mem_rdy,
    // REFILL -> IDLE unconditionally (one bubble)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IC_IDLE:   if (w_miss)  w_state_nxt = IC_MISS;
            IC_MISS:   if (mem_rdy) w_state_nxt = IC_REFILL;
            IC_REFILL: w_state_nxt = IC_IDLE;
            default:   w_state_nxt = IC_IDLE;
        endcase
    end

    // State register; async reset drops mem_re immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Line address latched at the miss and held for the whole request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr <= '0;
        end else if (w_miss) begin
            r_mem_addr <= pc[IC_PC_W-1:OFF_W];
        end
    end

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl. Main memory holds word(pc) = pc ^ KEY,
// so every expected instruction is known from the pc alone.
module tb_icache_fetch_ctrl;

    localparam logic [15:0] KEY = 16'hA5C3;
    localparam logic [15:0] NOP = 16'hB000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic        rd_en = 1'b0;
    logic        inv = 1'b0;
    logic [15:0] instr;
    logic        i_rdy;
    logic        mem_re;
    logic [13:0] mem_addr;
    logic        mem_rdy = 1'b0;
    logic [63:0] mem_rd_data = '0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    icache_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .rd_en       (rd_en),
        .inv         (inv),
        .instr       (instr),
        .i_rdy       (i_rdy),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_rdy     (mem_rdy),
        .mem_rd_data (mem_rd_data),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Main memory model: line at address la holds words (la*4+k) ^ KEY
    function automatic logic [63:0] line_of(input logic [13:0] la);
        logic [63:0] l;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a;
            a = {la, 2'b00} + 16'(k);
            l[k*16 +: 16] = a ^ KEY;
        end
        return l;
    endfunction

    // Memory responder: mem_rdy on the lat-th cycle of mem_re; stray pulses on request
    int lat = 3;
    bit stray = 1'b0;
    int rcnt = 0;
    always @(posedge clk) begin
        #2;
        if (mem_re) rcnt++;
        else rcnt = 0;
        mem_rdy = (mem_re && rcnt == lat) || stray;
        mem_rd_data = line_of(mem_re ? mem_addr : 14'h3FFF);
    end

    // Behavioural model: set of resident line addresses, plus whether a
    // fill is outstanding or just finished (one dead cycle after the fill)
    logic [7:0]  m_valid = '0;
    logic [13:0] m_la [8];
    bit          m_busy = 1'b0;
    bit          m_bubble = 1'b0;
    logic [13:0] m_addr = '0;

    function automatic bit m_hit(input logic [15:0] a);
        return m_valid[a[4:2]] && (m_la[a[4:2]] == a[15:2]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = '0;
            m_busy = 1'b0;
            m_bubble = 1'b0;
        end else begin
            if (m_bubble) begin
                m_bubble = 1'b0;
            end else if (m_busy) begin
                if (mem_rdy) begin
                    m_la[m_addr[2:0]] = m_addr;
                    m_valid[m_addr[2:0]] = 1'b1;
                    m_busy = 1'b0;
                    m_bubble = 1'b1;
                end
            end else if (rd_en && !m_hit(pc)) begin
                m_busy = 1'b1;
                m_addr = pc[15:2];
            end
            if (inv) m_valid = '0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            bit e_rdy;
            e_rdy = !m_busy && !m_bubble && rd_en && m_hit(pc);
            chk("i_rdy", 16'(i_rdy), 16'(e_rdy));
            chk("instr", instr, e_rdy ? (pc ^ KEY) : NOP);
            chk("mem_re", 16'(mem_re), 16'(m_busy));
            if (m_busy) chk("mem_addr", 16'(mem_addr), 16'(m_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the next rising edge of mem_re; returns at posedge+1
    task automatic wait_miss(input string name, input logic [13:0] exp_a);
        logic prev;
        bit seen;
        prev = mem_re;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mem_re && !prev) begin
                seen = 1'b1;
                chk(name, 16'(mem_addr), 16'(exp_a));
                break;
            end
            prev = mem_re;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no miss within 40 cycles, expected addr %h", name, exp_a);
        end
    endtask

    // Wait for i_rdy; returns at the negedge where it is seen
    task automatic wait_hit(input string name, input logic [15:0] exp_instr);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i_rdy) begin
                seen = 1'b1;
                chk(name, instr, exp_instr);
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: i_rdy not seen within 40 cycles, expected instr %h", name, exp_instr);
        end
    endtask

    initial begin
        int zeros;
        bit got_a;
        logic [13:0] first_a;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_rdy", 16'(i_rdy), 16'h0);
        chk("rst_instr", instr, 16'hB000);
        chk("rst_mem_re", 16'(mem_re), 16'h0);
        chk("rst_mem_addr", 16'(mem_addr), 16'h0);
        chk("rst_state", 16'(dbg_state), 16'h0);
        rst_n = 1'b1;

        // Cold miss: i_rdy low for 5 cycles with mem_rdy on the 3rd mem_re cycle
        lat = 3;
        pc = 16'h0000;
        rd_en = 1'b1;
        zeros = 0;
        got_a = 1'b0;
        first_a = '1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_re && !got_a) begin
                got_a = 1'b1;
                first_a = mem_addr;
            end
            if (i_rdy) break;
            zeros++;
        end
        chk("cold_stall_cycles", 16'(zeros), 16'd5);
        chk("cold_mem_addr", 16'(first_a), 16'h0000);
        chk("cold_instr", instr, 16'hA5C3);

        // Hit streak on words 1..3
        step(); pc = 16'h0001; @(negedge clk);
        chk("hit1_rdy", 16'(i_rdy), 16'h1); chk("hit1_instr", instr, 16'hA5C2);
        step(); pc = 16'h0002; @(negedge clk);
        chk("hit2_rdy", 16'(i_rdy), 16'h1); chk("hit2_instr", instr, 16'hA5C1);
        step(); pc = 16'h0003; @(negedge clk);
        chk("hit3_rdy", 16'(i_rdy), 16'h1); chk("hit3_instr", instr, 16'hA5C0);

        // Conflict on index 0
        step(); pc = 16'h0020;
        wait_miss("conflict_addr1", 14'h0008);
        wait_hit("conflict_instr1", 16'hA5E3);
        step(); pc = 16'h0000;
        wait_miss("conflict_addr2", 14'h0000);
        wait_hit("conflict_instr2", 16'hA5C3);

        // Flow change during MISS
        step(); pc = 16'h0010;
        wait_miss("flow_addr1", 14'h0004);
        step(); pc = 16'h0004;
        wait_miss("flow_addr2", 14'h0001);
        wait_hit("flow_instr", 16'hA5C7);

        // inv coincident with mem_rdy: re-miss on the same line
        lat = 2;
        step(); pc = 16'h0030;
        wait_miss("inv_addr1", 14'h000C);
        step(); inv = 1'b1;
        step(); inv = 1'b0;
        wait_miss("inv_remiss_addr", 14'h000C);
        wait_hit("inv_fill_instr", 16'hA5F3);

        // inv while IDLE on a hitting pc
        step(); inv = 1'b1; @(negedge clk);
        chk("inv_idle_hit", 16'(i_rdy), 16'h1);
        step(); inv = 1'b0; @(negedge clk);
        chk("inv_idle_miss", 16'(i_rdy), 16'h0);
        wait_miss("inv_idle_addr", 14'h000C);
        wait_hit("inv_idle_instr", 16'hA5F3);

        // Stray mem_rdy in IDLE is ignored
        step(); stray = 1'b1; @(negedge clk);
        chk("stray_hit", 16'(i_rdy), 16'h1);
        step(); stray = 1'b0; @(negedge clk);
        chk("stray_after", 16'(i_rdy), 16'h1);

        // rd_en low in IDLE: no miss; rd_en dropping in MISS: fill completes
        lat = 3;
        step(); rd_en = 1'b0; pc = 16'h0044;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rden0_rdy", 16'(i_rdy), 16'h0);
            chk("rden0_mem_re", 16'(mem_re), 16'h0);
            step();
        end
        rd_en = 1'b1;
        wait_miss("rden_addr", 14'h0011);
        step(); rd_en = 1'b0;
        repeat (5) step();
        rd_en = 1'b1; @(negedge clk);
        chk("rden_drop_hit", 16'(i_rdy), 16'h1);
        chk("rden_drop_instr", instr, 16'hA587);

        // Reset mid-MISS: outputs drop without a clock edge
        lat = 50;
        step(); pc = 16'h0008;
        wait_miss("rstmiss_addr", 14'h0002);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmiss_mem_re", 16'(mem_re), 16'h0);
        chk("rstmiss_i_rdy", 16'(i_rdy), 16'h0);
        chk("rstmiss_instr", instr, 16'hB000);
        lat = 3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pc = 16'h0030;
        @(negedge clk);
        chk("rstmiss_refetch_miss", 16'(i_rdy), 16'h0);
        wait_miss("rstmiss_refetch_addr", 14'h000C);
        wait_hit("rstmiss_refetch_instr", 16'hA5F3);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
